// File: rtl/ram_arbiter_2ch_if.sv
// ram_arbiter_2ch_if
//   Request/response bundle for one client channel of ram_arbiter_2ch.
//   One instance per channel.
//   Signals:
//     req    client -> arbiter  request; held with the command stable until ack
//     we     client -> arbiter  1 = write, 0 = read
//     addr   client -> arbiter  word address
//     wdata  client -> arbiter  write data
//     ack    arbiter -> client  one-cycle pulse when the transaction completes
//     rdata  arbiter -> client  read data; valid in the ack cycle of a read, then held
//   Modports:
//     master  the client side (drives the command)
//     slave   the arbiter side (drives ack/rdata)
interface ram_arbiter_2ch_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/ram_arbiter_2ch.sv
// ram_arbiter_2ch
//   Shares one single-port RAM between two clients.
//   - Arbitration is round-robin.
//   - Only one transaction is in flight at a time.
//   - The arbiter owns every RAM control pin.
//   - Every output is registered.
//   Parameters:
//     ADDR_W  RAM address width
//     DATA_W  RAM data width
//     RD_LAT  cycles from the read-issue edge to ram_rd_data valid (1..3)
//   Ports:
//     sys_clk      clock; all logic on the rising edge
//     sys_rst      asynchronous active-low reset
//     c0, c1       client channels (slave side of ram_arbiter_2ch_if)
//     ram_en       RAM enable, high for exactly one cycle per transaction
//     ram_we       RAM write enable; only ever high together with ram_en
//     ram_addr     RAM address
//     ram_wr_data  RAM write data
//     ram_rd_data  RAM read data
//     busy         high while a transaction is in progress (state != IDLE)
//     gnt_id       channel owning the current or last transaction
module ram_arbiter_2ch #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    ram_arbiter_2ch_if.slave    c0,
    ram_arbiter_2ch_if.slave    c1,
    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wr_data,
    input  logic [DATA_W-1:0]   ram_rd_data,
    output logic                busy,
    output logic                gnt_id
);
    localparam int CNT_W = 2;  // RD_LAT - 1 never exceeds 2

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rr_last_q, rr_last_d;
    logic                gnt_id_q, gnt_id_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wr_data_q, ram_wr_data_d;
    logic                busy_q, busy_d;
    logic [1:0]          ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q [2];
    logic [DATA_W-1:0]   rdata_d [2];

    // Channel inputs gathered into arrays so the channels can be indexed by gnt_id.
    logic [1:0]          req;
    logic [1:0]          we;
    logic [ADDR_W-1:0]   addr  [2];
    logic [DATA_W-1:0]   wdata [2];
    logic                winner;

    assign req      = {c1.req, c0.req};
    assign we       = {c1.we, c0.we};
    assign addr[0]  = c0.addr;
    assign addr[1]  = c1.addr;
    assign wdata[0] = c0.wdata;
    assign wdata[1] = c1.wdata;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rr_last_d     = rr_last_q;
        gnt_id_d      = gnt_id_q;
        ram_en_d      = 1'b0;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        ack_d         = 2'b00;
        rdata_d       = rdata_q;
        // On a tie, the channel that did not win last time goes next.
        // Otherwise the single requester wins.
        winner        = (req[0] && req[1]) ? ~rr_last_q : req[1];

        case (state_q)
            IDLE: begin
                if (|req) begin
                    // Latch the command now; the RAM pins themselves act as the latch,
                    // so later changes on the client side cannot affect this transaction.
                    gnt_id_d      = winner;
                    rr_last_d     = winner;
                    ram_en_d      = 1'b1;
                    ram_we_d      = we[winner];
                    ram_addr_d    = addr[winner];
                    ram_wr_data_d = wdata[winner];
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                // ram_we_q still holds the latched direction during ISSUE.
                if (ram_we_q) begin
                    ack_d[gnt_id_q] = 1'b1;
                    state_d         = RESP;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d[gnt_id_q] = ram_rd_data;
                    ack_d[gnt_id_q]   = 1'b1;
                    state_d           = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rr_last_q     <= 1'b1;
            gnt_id_q      <= 1'b0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
            busy_q        <= 1'b0;
            ack_q         <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rr_last_q     <= rr_last_d;
            gnt_id_q      <= gnt_id_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            busy_q        <= busy_d;
            ack_q         <= ack_d;
            for (int i = 0; i < 2; i++) begin
                rdata_q[i] <= rdata_d[i];
            end
        end
    end

    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wr_data = ram_wr_data_q;
    assign busy        = busy_q;
    assign gnt_id      = gnt_id_q;
    assign c0.ack      = ack_q[0];
    assign c1.ack      = ack_q[1];
    assign c0.rdata    = rdata_q[0];
    assign c1.rdata    = rdata_q[1];
endmodule

// File: tb/tb_ram_arbiter_2ch.sv
// tb_ram_arbiter_2ch
//   Bench for ram_arbiter_2ch. Two instances run against behavioural RAMs:
//     instance 0  RD_LAT = 1
//     instance 1  RD_LAT = 3
//   The reference model is transaction level:
//     - it grants whenever the arbiter is idle;
//     - it predicts the ack cycle from the latency rules;
//     - it keeps a shadow copy of the memory contents.
module tb_ram_arbiter_2ch;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n       [2];
    logic       req         [2][2];
    logic       we          [2][2];
    logic [4:0] addr        [2][2];
    logic [7:0] wdata       [2][2];
    logic       ack         [2][2];
    logic [7:0] rdata       [2][2];
    logic       ram_en      [2];
    logic       ram_we      [2];
    logic [4:0] ram_addr    [2];
    logic [7:0] ram_wr_data [2];
    logic [7:0] ram_rd_data [2];
    logic       busy        [2];
    logic       gnt_id      [2];

    function automatic logic [7:0] init_val(int i, int a);
        return (a == 31) ? 8'h3C : 8'(a * 37 + i * 11 + 1);
    endfunction

    function automatic int lat(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            ram_arbiter_2ch_if #(.ADDR_W(5), .DATA_W(8)) c0_if ();
            ram_arbiter_2ch_if #(.ADDR_W(5), .DATA_W(8)) c1_if ();

            assign c0_if.req   = req[gi][0];
            assign c0_if.we    = we[gi][0];
            assign c0_if.addr  = addr[gi][0];
            assign c0_if.wdata = wdata[gi][0];
            assign c1_if.req   = req[gi][1];
            assign c1_if.we    = we[gi][1];
            assign c1_if.addr  = addr[gi][1];
            assign c1_if.wdata = wdata[gi][1];
            assign ack[gi][0]   = c0_if.ack;
            assign ack[gi][1]   = c1_if.ack;
            assign rdata[gi][0] = c0_if.rdata;
            assign rdata[gi][1] = c1_if.rdata;

            ram_arbiter_2ch #(.ADDR_W(5), .DATA_W(8), .RD_LAT(gi == 0 ? 1 : 3)) u_dut (
                .sys_clk     (clk),
                .sys_rst     (rst_n[gi]),
                .c0          (c0_if),
                .c1          (c1_if),
                .ram_en      (ram_en[gi]),
                .ram_we      (ram_we[gi]),
                .ram_addr    (ram_addr[gi]),
                .ram_wr_data (ram_wr_data[gi]),
                .ram_rd_data (ram_rd_data[gi]),
                .busy        (busy[gi]),
                .gnt_id      (gnt_id[gi])
            );

            // Single-port RAM with a registered read.
            // For RD_LAT = 3 the read data passes through two extra pipeline stages.
            logic [7:0] mem [32];
            logic [7:0] p0, p1, p2;
            initial begin
                for (int a = 0; a < 32; a++) mem[a] <= init_val(gi, a);
                p0 <= 8'h00;
                p1 <= 8'h00;
                p2 <= 8'h00;
            end
            always @(posedge clk) begin
                if (ram_en[gi]) begin
                    if (ram_we[gi]) mem[ram_addr[gi]] <= ram_wr_data[gi];
                    else            p0 <= mem[ram_addr[gi]];
                end
                p1 <= p0;
                p2 <= p1;
            end
            assign ram_rd_data[gi] = (gi == 0) ? p0 : p2;
        end
    endgenerate

    // Reference model state, per instance.
    int         checks = 0;
    int         errors = 0;
    int         g_cyc   [2];
    int         a_cyc   [2];
    bit         g_ch    [2];
    bit         g_we    [2];
    logic [4:0] g_addr  [2];
    logic [7:0] g_wdata [2];
    logic [7:0] pend_rd [2];
    bit         rr_last [2];
    bit         exp_gnt [2];
    logic [7:0] exp_rd  [2][2];
    logic [7:0] ref_mem [2][32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic model_reset(input int i);
        g_cyc[i]     = -100;
        a_cyc[i]     = -100;
        rr_last[i]   = 1'b1;
        exp_gnt[i]   = 1'b0;
        exp_rd[i][0] = 8'h00;
        exp_rd[i][1] = 8'h00;
    endtask

    task automatic drive_idle(input int i);
        for (int c = 0; c < 2; c++) begin
            req[i][c]   = 1'b0;
            we[i][c]    = 1'b0;
            addr[i][c]  = 5'd0;
            wdata[i][c] = 8'd0;
        end
    endtask

    task automatic new_cmd(input int i, input int c);
        req[i][c]   = 1'b1;
        we[i][c]    = 1'($urandom % 2);
        addr[i][c]  = 5'($urandom % 32);
        wdata[i][c] = 8'($urandom % 256);
    endtask

    // Compare every output of instance i for the current cycle against the model.
    task automatic check_outputs(input int i);
        bit exp_en;
        int t;
        t = cyc;
        // The edge ending the ISSUE cycle performs the RAM access.
        if (t == g_cyc[i] + 1) begin
            if (g_we[i]) ref_mem[i][g_addr[i]] = g_wdata[i];
            else         pend_rd[i] = ref_mem[i][g_addr[i]];
        end
        if (t == a_cyc[i] && !g_we[i]) exp_rd[i][g_ch[i]] = pend_rd[i];
        exp_en = (t == g_cyc[i] + 1);
        chk($sformatf("i%0d_ram_en", i), 32'(ram_en[i]), 32'(exp_en));
        chk($sformatf("i%0d_ram_we", i), 32'(ram_we[i]), 32'(exp_en && g_we[i]));
        if (exp_en) begin
            chk($sformatf("i%0d_ram_addr", i), 32'(ram_addr[i]), 32'(g_addr[i]));
            chk($sformatf("i%0d_ram_wr_data", i), 32'(ram_wr_data[i]), 32'(g_wdata[i]));
        end
        chk($sformatf("i%0d_busy", i), 32'(busy[i]), 32'(t > g_cyc[i] && t <= a_cyc[i]));
        chk($sformatf("i%0d_gnt_id", i), 32'(gnt_id[i]), 32'(exp_gnt[i]));
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("i%0d_c%0d_ack", i, c), 32'(ack[i][c]),
                32'(t == a_cyc[i] && g_ch[i] == c));
            chk($sformatf("i%0d_c%0d_rdata", i, c), 32'(rdata[i][c]), 32'(exp_rd[i][c]));
        end
    endtask

    // The inputs driven during cycle t are sampled by the arbiter at the edge ending t.
    task automatic model_sample(input int i);
        bit w;
        if (cyc > a_cyc[i] && (req[i][0] || req[i][1])) begin
            w          = (req[i][0] && req[i][1]) ? !rr_last[i] : req[i][1];
            g_ch[i]    = w;
            g_we[i]    = we[i][w];
            g_addr[i]  = addr[i][w];
            g_wdata[i] = wdata[i][w];
            g_cyc[i]   = cyc;
            a_cyc[i]   = cyc + 2 + (we[i][w] ? 0 : lat(i));
            rr_last[i] = w;
            exp_gnt[i] = w;
        end
    endtask

    task automatic tick(input int i);
        @(negedge clk);
        check_outputs(i);
    endtask

    // Drives one cycle of random traffic that obeys the requester protocol.
    // The granted channel may also scramble or drop its command mid-transaction.
    task automatic random_step(input int i, input bit hold_both);
        bit acked;
        for (int c = 0; c < 2; c++) begin
            acked = (cyc == a_cyc[i]) && (g_ch[i] == c);
            if (acked) begin
                if (!hold_both && ($urandom % 2 == 0)) req[i][c] = 1'b0;
                else                                   new_cmd(i, c);
            end else if (!req[i][c]) begin
                if (hold_both || ($urandom % 3 == 0)) new_cmd(i, c);
            end else if (!hold_both && g_ch[i] == c && cyc > g_cyc[i] && cyc < a_cyc[i]
                         && ($urandom % 6 == 0)) begin
                if ($urandom % 2 == 0) req[i][c] = 1'b0;
                else begin
                    we[i][c]    = 1'($urandom % 2);
                    addr[i][c]  = 5'($urandom % 32);
                    wdata[i][c] = 8'($urandom % 256);
                end
            end
        end
        model_sample(i);
    endtask

    // Lets outstanding requests finish; each channel drops req after its ack.
    task automatic drain(input int i);
        repeat (15) begin
            tick(i);
            for (int c = 0; c < 2; c++) begin
                if (cyc == a_cyc[i] && g_ch[i] == c) req[i][c] = 1'b0;
            end
            model_sample(i);
        end
    endtask

    int  n_ack;
    bit  prev_ch;
    logic [7:0] exp_val;

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 32; a++) ref_mem[i][a] = init_val(i, a);
            model_reset(i);
            drive_idle(i);
            rst_n[i] = 1'b0;
        end
        repeat (2) @(negedge clk);

        // Reset state of both instances.
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst%0d_ram_en", i), 32'(ram_en[i]), 32'd0);
            chk($sformatf("rst%0d_ram_we", i), 32'(ram_we[i]), 32'd0);
            chk($sformatf("rst%0d_ram_addr", i), 32'(ram_addr[i]), 32'd0);
            chk($sformatf("rst%0d_ram_wr_data", i), 32'(ram_wr_data[i]), 32'd0);
            chk($sformatf("rst%0d_busy", i), 32'(busy[i]), 32'd0);
            chk($sformatf("rst%0d_gnt_id", i), 32'(gnt_id[i]), 32'd0);
            chk($sformatf("rst%0d_acks", i), 32'({ack[i][1], ack[i][0]}), 32'd0);
            chk($sformatf("rst%0d_rdata", i), 32'({rdata[i][1], rdata[i][0]}), 32'd0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // c0 writes 8'hA5 to address 5.
        tick(0);
        req[0][0] = 1'b1; we[0][0] = 1'b1; addr[0][0] = 5'd5; wdata[0][0] = 8'hA5;
        model_sample(0);
        tick(0);
        chk("wr_c1_ram_en", 32'(ram_en[0]), 32'd1);
        chk("wr_c1_ram_we", 32'(ram_we[0]), 32'd1);
        chk("wr_c1_ram_addr", 32'(ram_addr[0]), 32'd5);
        chk("wr_c1_ram_din", 32'(ram_wr_data[0]), 32'hA5);
        model_sample(0);
        tick(0);
        chk("wr_c2_c0_ack", 32'(ack[0][0]), 32'd1);

        // c1 reads address 5 back.
        req[0][0] = 1'b0;
        req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 5'd5; wdata[0][1] = 8'h00;
        model_sample(0);
        tick(0);
        model_sample(0);
        repeat (2) begin
            tick(0);
            chk("rd_early_c1_ack", 32'(ack[0][1]), 32'd0);
            model_sample(0);
        end
        tick(0);
        chk("rd_c3_c1_ack", 32'(ack[0][1]), 32'd1);
        chk("rd_c3_c1_rdata", 32'(rdata[0][1]), 32'hA5);
        chk("rd_c3_c0_rdata", 32'(rdata[0][0]), 32'h00);
        req[0][1] = 1'b0;
        model_sample(0);

        // Reset asserted during the ISSUE cycle of a read.
        tick(0);
        req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 5'd9;
        model_sample(0);
        tick(0);
        chk("rst_issue_ram_en_before", 32'(ram_en[0]), 32'd1);
        rst_n[0] = 1'b0;
        #1;
        chk("rst_mid_ram_en", 32'(ram_en[0]), 32'd0);
        chk("rst_mid_ram_we", 32'(ram_we[0]), 32'd0);
        chk("rst_mid_busy", 32'(busy[0]), 32'd0);
        chk("rst_mid_acks", 32'({ack[0][1], ack[0][0]}), 32'd0);
        chk("rst_mid_c1_rdata", 32'(rdata[0][1]), 32'd0);
        drive_idle(0);
        model_reset(0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        tick(0);

        // Both channels request in the same cycle and keep requesting.
        // Grants must alternate 0,1,0,1...
        new_cmd(0, 0);
        new_cmd(0, 1);
        model_sample(0);
        n_ack = 0;
        repeat (40) begin
            tick(0);
            if (ack[0][0] || ack[0][1]) begin
                chk("alt_ack_ch", 32'(ack[0][1]), 32'(n_ack % 2));
                chk("alt_gnt_id", 32'(gnt_id[0]), 32'(ack[0][1]));
                n_ack++;
            end
            random_step(0, 1'b1);
        end
        chk("alt_ack_count_ge8", 32'(n_ack >= 8), 32'd1);
        drain(0);

        // c0 drops req and changes its address during ISSUE: the latched read still completes.
        tick(0);
        req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 5'd7;
        model_sample(0);
        exp_val = ref_mem[0][7];
        tick(0);
        chk("chg_issue_addr", 32'(ram_addr[0]), 32'd7);
        addr[0][0] = 5'd9;
        req[0][0]  = 1'b0;
        model_sample(0);
        n_ack = 0;
        repeat (6) begin
            tick(0);
            if (ack[0][0]) n_ack++;
            model_sample(0);
        end
        chk("chg_one_ack", 32'(n_ack), 32'd1);
        chk("chg_rdata", 32'(rdata[0][0]), 32'(exp_val));

        // RD_LAT = 3 instance: read address 31 (preloaded with 8'h3C).
        tick(1);
        req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 5'd31;
        model_sample(1);
        repeat (4) begin
            tick(1);
            chk("lat3_early_ack", 32'(ack[1][0]), 32'd0);
            model_sample(1);
        end
        tick(1);
        chk("lat3_c5_ack", 32'(ack[1][0]), 32'd1);
        chk("lat3_c5_rdata", 32'(rdata[1][0]), 32'h3C);
        req[1][0] = 1'b0;
        model_sample(1);

        // Random traffic on both instances.
        repeat (400) begin
            tick(0);
            random_step(0, 1'b0);
        end
        drain(0);
        repeat (400) begin
            tick(1);
            random_step(1, 1'b0);
        end
        drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
